ram_block: RTL and testbench

RAM_BLOCK -- requirements
Module: ram_block

---
 rtl/ram_block.sv | 85 ++++++++
 tb/tb_ram_block.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/ram_block.sv
// ram_block: single-port synchronous RAM with registered read data.
//
// Depth is 2**ADDR_WIDTH words of DATA_WIDTH bits. Every rising clk edge
// performs exactly one access on addr: a write when wen=1, a read when wen=0.
// dataout is loaded on that edge, so read latency is one clock.
//
// Reset (rst, active-low, asynchronous) clears every memory word and dataout
// immediately, without waiting for clk. Accesses are ignored while rst=0.
//
// Optional feature macro: RAM_WRITE_THROUGH_EN
//   undefined (default) : a write cycle loads dataout with the old word
//                         (read-before-write).
//   defined             : a write cycle loads dataout with datain
//                         (write-through).
//
// Ports:
//   clk     in  1           clock, rising edge
//   rst     in  1           asynchronous reset, active-low
//   addr    in  ADDR_WIDTH  word address for read and write
//   datain  in  DATA_WIDTH  write data
//   wen     in  1           1 = write, 0 = read
//   dataout out DATA_WIDTH  registered read data
module ram_block #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] datain,
  input  logic                  wen,
  output logic [DATA_WIDTH-1:0] dataout
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  // Storage is built from resettable flops because reset must clear every
  // word asynchronously; a macro RAM array could not honour that.
  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  logic [DATA_WIDTH-1:0] dout_r;
  logic [DATA_WIDTH-1:0] dout_next_s;
  logic [DATA_WIDTH-1:0] rd_word_s;

  // Combinational read of the addressed word (old contents on a write cycle).
  always_comb begin
    rd_word_s = mem_r[addr];
  end

  // Select what dataout loads on the next edge.
  always_comb begin
    dout_next_s = rd_word_s;
`ifdef RAM_WRITE_THROUGH_EN
    if (wen) begin
      dout_next_s = datain;
    end else begin
      dout_next_s = rd_word_s;
    end
`else
    dout_next_s = rd_word_s;
`endif
  end

  // Memory array: asynchronous clear, otherwise write on wen.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {DATA_WIDTH{1'b0}};
      end
    end else if (wen) begin
      mem_r[addr] <= datain;
    end
  end

  // Output data register: the only driver of dataout.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dout_r <= {DATA_WIDTH{1'b0}};
    end else begin
      dout_r <= dout_next_s;
    end
  end

  assign dataout = dout_r;

endmodule

// File: tb/tb_ram_block.sv
// Testbench for ram_block: directed vectors with hand-computed expectations.
// The stimulus process pushes one expected entry per clocked access; the
// monitor pops it 1 time unit after the following rising edge and compares.
module tb_ram_block;

  logic       clk;
  logic       rst;
  logic [3:0] addr;
  logic [7:0] datain;
  logic       wen;
  logic [7:0] dataout;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit         chk;
    logic [7:0] exp;
    string      name;
  } exp_t;

  exp_t sb_q[$];

  ram_block #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .addr    (addr),
    .datain  (datain),
    .wen     (wen),
    .dataout (dataout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pick the expected dataout of a write cycle for the current build.
  function automatic logic [7:0] wsel(input logic [7:0] rbw, input logic [7:0] wt);
`ifdef RAM_WRITE_THROUGH_EN
    return wt;
`else
    return rbw;
`endif
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: dataout=%02h expected=%02h at %0t", name, act, exp, $time);
    end
  endtask

  // One access: called at a negedge, drives inputs, queues the expectation,
  // returns at the next negedge.
  task automatic cyc(input logic [3:0] a, input logic [7:0] d, input logic w,
                     input logic [7:0] exp, input bit chk, input string name);
    exp_t e;
    addr = a; datain = d; wen = w;
    e.chk = chk; e.exp = exp; e.name = name;
    sb_q.push_back(e);
    @(negedge clk);
  endtask

  // Monitor: dataout is valid just after each rising edge for the access
  // queued at the preceding negedge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      if (e.chk) check(e.name, dataout, e.exp);
    end
  end

  initial begin
    rst = 1'b0; addr = 4'd0; datain = 8'h00; wen = 1'b0;
    // Reset state, with a write attempt presented during reset.
    @(posedge clk); #1;
    check("reset_state0", dataout, 8'h00);
    wen = 1'b1; addr = 4'd4; datain = 8'h99;
    @(posedge clk); #1;
    check("reset_state1", dataout, 8'h00);
    @(negedge clk);
    rst = 1'b1;

    // Boundary addresses.
    cyc(4'd0,  8'h3C, 1'b1, wsel(8'h00, 8'h3C), 1'b1, "wr_a0");
    cyc(4'd15, 8'hC3, 1'b1, wsel(8'h00, 8'hC3), 1'b1, "wr_a15");
    cyc(4'd0,  8'h00, 1'b0, 8'h3C, 1'b1, "rd_a0");
    cyc(4'd15, 8'h00, 1'b0, 8'hC3, 1'b1, "rd_a15");
    cyc(4'd4,  8'h00, 1'b0, 8'h00, 1'b1, "rd_a4_ignored_wr");

    // Back-to-back writes to one address.
    cyc(4'd7, 8'h11, 1'b1, wsel(8'h00, 8'h11), 1'b1, "wr_a7_first");
    cyc(4'd7, 8'h22, 1'b1, wsel(8'h11, 8'h22), 1'b1, "wr_a7_second");
    cyc(4'd7, 8'h00, 1'b0, 8'h22, 1'b1, "rd_a7");

    // Read-before-write vs write-through, then read right after the write.
    cyc(4'd2, 8'h55, 1'b1, wsel(8'h00, 8'h55), 1'b1, "wr_a2_55");
    cyc(4'd2, 8'hAA, 1'b1, wsel(8'h55, 8'hAA), 1'b1, "wr_a2_aa_dout");
    cyc(4'd2, 8'h00, 1'b0, 8'hAA, 1'b1, "rd_a2_after_wr");

    // Reset asserted mid-run, in the middle of a write to addr 3.
    cyc(4'd3, 8'hA5, 1'b1, wsel(8'h00, 8'hA5), 1'b1, "wr_a3_a5");
    cyc(4'd3, 8'h00, 1'b0, 8'hA5, 1'b1, "rd_a3_before_rst");
    addr = 4'd3; datain = 8'h77; wen = 1'b1;
    #2 rst = 1'b0;
    #1 check("rst_async_clear", dataout, 8'h00);
    @(posedge clk); #1;
    check("rst_hold0", dataout, 8'h00);
    @(posedge clk); #1;
    check("rst_hold1", dataout, 8'h00);
    @(negedge clk);
    rst = 1'b1;
    cyc(4'd3,  8'h00, 1'b0, 8'h00, 1'b1, "rd_a3_after_rst");
    cyc(4'd15, 8'h00, 1'b0, 8'h00, 1'b1, "rd_a15_after_rst");
    cyc(4'd2,  8'h00, 1'b0, 8'h00, 1'b1, "rd_a2_after_rst");

    // Fill every word with addr*17 (0x00, 0x11, ... 0xFF), then read back.
    for (int i = 0; i < 16; i++) begin
      cyc(4'(i), 8'(i * 17), 1'b1, wsel(8'h00, 8'(i * 17)), 1'b1, "fill_wr");
    end
    for (int i = 0; i < 16; i++) begin
      cyc(4'(i), 8'h00, 1'b0, 8'(i * 17), 1'b1, "fill_rd");
    end

    // dataout must not follow addr between clock edges.
    begin
      exp_t e;
      addr = 4'd5; datain = 8'h00; wen = 1'b0;
      e.chk = 1'b1; e.exp = 8'h55; e.name = "rd_a5";
      sb_q.push_back(e);
      @(posedge clk);
      #3 addr = 4'd9;
      #1 check("hold_between_edges", dataout, 8'h55);
      @(negedge clk);
      check("hold_at_negedge", dataout, 8'h55);
    end
    cyc(4'd9, 8'h00, 1'b0, 8'h99, 1'b1, "rd_a9");

    // Drain the scoreboard within a bounded number of cycles.
    for (int n = 0; n < 20 && sb_q.size() > 0; n++) @(negedge clk);
    if (sb_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: pending=%0d expected=0", sb_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
